// File: rtl/cp_latch.sv
// cp_latch: registered storage cell with synchronous clear/preset/hold controls.
// Each rising edge performs one of load, preset, clear or hold, chosen by {c, p}.
// Reset has the highest priority. data_out always comes straight from the register.
module cp_latch #(
  parameter int unsigned           WIDTH        = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]      PRESET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]      CLEAR_VALUE  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c,
  input  logic             p,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state select. c=1,p=1 keeps the current value and ignores data_in.
  always_comb begin
    data_d = data_q;
    unique case ({c, p})
      2'b00:   data_d = data_in;
      2'b01:   data_d = PRESET_VALUE;
      2'b10:   data_d = CLEAR_VALUE;
      2'b11:   data_d = data_q;
      default: data_d = data_q;
    endcase
  end

  // State register with synchronous reset that overrides every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

  // Unknown mode selects would otherwise silently fall into the hold branch.
  cp_known_a : assert property (@(posedge clk) !rst |-> !$isunknown({c, p}))
    else $error("cp_latch: unknown c/p while out of reset");

endmodule

// File: tb/tb_cp_latch.sv
// Directed bench for cp_latch at the default 1-bit width.
module tb_cp_latch;

  logic clk;
  logic rst;
  logic c;
  logic p;
  logic [0:0] data_in;
  logic [0:0] data_out;

  int vectors;
  int miscompares;

  cp_latch dut (
    .clk      (clk),
    .rst      (rst),
    .c        (c),
    .p        (p),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled and inputs changed 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [0:0] expected, input string tag);
    vectors++;
    assert (data_out === expected)
    else begin
      miscompares++;
      $error("FAIL %s: data_out=%0b expected=%0b", tag, data_out, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    c       = 1'b0;
    p       = 1'b0;
    data_in = 1'b1;

    // Reset held for two edges while load of 1 is requested.
    step(); check(1'b0, "reset_edge1");
    step(); check(1'b0, "reset_edge2");
    rst = 1'b0;
    step(); check(1'b1, "reset_release_load");

    // Load follows data_in one cycle late.
    data_in = 1'b1; step(); check(1'b1, "load_1");
    data_in = 1'b0; step(); check(1'b0, "load_0");
    data_in = 1'b1; step(); check(1'b1, "load_1b");

    // Preset with data_in=0, held for several cycles.
    data_in = 1'b0; p = 1'b1;
    step(); check(1'b1, "preset_1");
    step(); check(1'b1, "preset_2");
    step(); check(1'b1, "preset_3");

    // Clear with data_in=1.
    c = 1'b1; p = 1'b0; data_in = 1'b1;
    step(); check(1'b0, "clear");

    // Hold a loaded 1 while data_in toggles.
    c = 1'b0; p = 1'b0; data_in = 1'b1;
    step(); check(1'b1, "hold1_load");
    c = 1'b1; p = 1'b1;
    data_in = 1'b0; step(); check(1'b1, "hold1_a");
    data_in = 1'b1; step(); check(1'b1, "hold1_b");
    data_in = 1'b0; step(); check(1'b1, "hold1_c");

    // Hold a loaded 0 while data_in toggles.
    c = 1'b0; p = 1'b0; data_in = 1'b0;
    step(); check(1'b0, "hold0_load");
    c = 1'b1; p = 1'b1;
    data_in = 1'b1; step(); check(1'b0, "hold0_a");
    data_in = 1'b0; step(); check(1'b0, "hold0_b");
    data_in = 1'b1; step(); check(1'b0, "hold0_c");

    // Back-to-back mode switches, one result per edge.
    c = 1'b0; p = 1'b0; data_in = 1'b0; step(); check(1'b0, "b2b_load0");
    c = 1'b0; p = 1'b1; data_in = 1'b0; step(); check(1'b1, "b2b_preset");
    c = 1'b1; p = 1'b0; data_in = 1'b1; step(); check(1'b0, "b2b_clear");
    c = 1'b0; p = 1'b0; data_in = 1'b1; step(); check(1'b1, "b2b_load1");
    c = 1'b1; p = 1'b1; data_in = 1'b0; step(); check(1'b1, "b2b_hold");

    // Only the value present at the edge is loaded, not an earlier glitch.
    c = 1'b0; p = 1'b0; data_in = 1'b0;
    step(); check(1'b0, "glitch_base");
    data_in = 1'b1; #3; data_in = 1'b0;
    step(); check(1'b0, "glitch_ignored");

    // Reset overrides a hold of 1; hold afterwards keeps the reset value.
    data_in = 1'b1; step(); check(1'b1, "rstpri_load");
    c = 1'b1; p = 1'b1; step(); check(1'b1, "rstpri_hold");
    rst = 1'b1; step(); check(1'b0, "rstpri_reset");
    rst = 1'b0; data_in = 1'b1; step(); check(1'b0, "rstpri_hold_after_a");
    step(); check(1'b0, "rstpri_hold_after_b");

    // Reset overrides a preset request.
    c = 1'b0; p = 1'b1; rst = 1'b1; step(); check(1'b0, "rst_over_preset");
    rst = 1'b0; step(); check(1'b1, "preset_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
